// File: rtl/imm_pkg.sv
// Shared opcode constants, format codes and payload types for the immediate generator.
// The IMM_GEN_ANDI_ZEXT_EN build option is consumed by imm_decode_comb.
package imm_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned OPC_W   = 7;
    localparam int unsigned F3_W    = 3;
    localparam int unsigned FMT_W   = 3;
    localparam int unsigned CNT_W   = 16;

    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;

    localparam logic [F3_W-1:0] F3_SLLI = 3'b001;
    localparam logic [F3_W-1:0] F3_SRXI = 3'b101;
    localparam logic [F3_W-1:0] F3_ANDI = 3'b111;

    typedef enum logic [FMT_W-1:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_ILL = 3'd7
    } imm_fmt_e;

    // Per-entry decode metadata carried alongside the immediate and tag.
    typedef struct packed {
        imm_fmt_e fmt;
        logic     illegal;
    } imm_meta_t;

endpackage

// File: rtl/imm_decode_comb.sv
// Pure combinational opcode decode and immediate extraction, sign-extended to XLEN.
// IMM_GEN_ANDI_ZEXT_EN: when defined, ANDI immediates are zero-extended.
module imm_decode_comb
    import imm_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [INSTR_W-1:0] instr,
    output logic [XLEN-1:0]    imm,
    output imm_fmt_e           fmt,
    output logic               illegal
);

    logic [OPC_W-1:0] opcode;
    logic [F3_W-1:0]  funct3;
    logic [XLEN-1:0]  imm_i;
    logic [XLEN-1:0]  imm_s;
    logic [XLEN-1:0]  imm_b;
    logic [XLEN-1:0]  imm_u;
    logic [XLEN-1:0]  imm_j;
    logic [XLEN-1:0]  imm_shamt;
    logic [XLEN-1:0]  imm_andi;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];

    assign imm_i = XLEN'($signed(instr[31:20]));
    assign imm_s = XLEN'($signed({instr[31:25], instr[11:7]}));
    assign imm_b = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({instr[31:12], 12'b0}));
    assign imm_j = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));

    // RV64 shifts carry a 6-bit shamt, RV32 only 5 bits.
    generate
        if (XLEN == 64) begin : g_shamt64
            assign imm_shamt = XLEN'(instr[25:20]);
        end else begin : g_shamt32
            assign imm_shamt = XLEN'(instr[24:20]);
        end
    endgenerate

`ifdef IMM_GEN_ANDI_ZEXT_EN
    assign imm_andi = XLEN'(instr[31:20]);
`else
    assign imm_andi = imm_i;
`endif

    always_comb begin
        imm     = '0;
        fmt     = FMT_ILL;
        illegal = 1'b0;
        case (opcode)
            OPC_LOAD, OPC_JALR: begin
                fmt = FMT_I;
                imm = imm_i;
            end
            OPC_OP_IMM: begin
                fmt = FMT_I;
                if ((funct3 == F3_SLLI) || (funct3 == F3_SRXI)) begin
                    imm = imm_shamt;
                end else if (funct3 == F3_ANDI) begin
                    imm = imm_andi;
                end else begin
                    imm = imm_i;
                end
            end
            OPC_STORE: begin
                fmt = FMT_S;
                imm = imm_s;
            end
            OPC_BRANCH: begin
                fmt = FMT_B;
                imm = imm_b;
            end
            OPC_LUI, OPC_AUIPC: begin
                fmt = FMT_U;
                imm = imm_u;
            end
            OPC_JAL: begin
                fmt = FMT_J;
                imm = imm_j;
            end
            OPC_OP: begin
                fmt = FMT_R;
            end
            default: begin
                fmt     = FMT_ILL;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Latency-1 immediate generator with an output register plus one skid entry.
// Decode lives in imm_decode_comb (IMM_GEN_ANDI_ZEXT_EN selects ANDI extension there).
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_imm,
    output logic [FMT_W-1:0]   out_fmt,
    output logic               out_illegal,
    output logic [TAG_W-1:0]   out_tag,
    output logic [CNT_W-1:0]   illegal_cnt
);

    logic [XLEN-1:0]  dec_imm;
    imm_fmt_e         dec_fmt;
    logic             dec_illegal;
    imm_meta_t        dec_meta;

    logic             out_valid_q;
    logic [XLEN-1:0]  out_imm_q;
    imm_meta_t        out_meta_q;
    logic [TAG_W-1:0] out_tag_q;

    logic             skid_valid_q;
    logic [XLEN-1:0]  skid_imm_q;
    imm_meta_t        skid_meta_q;
    logic [TAG_W-1:0] skid_tag_q;

    logic             in_ready_q;
    logic [CNT_W-1:0] cnt_q;

    logic             accept;
    logic             drain;
    logic             out_valid_d;
    logic             skid_valid_d;
    logic             load_out;
    logic             out_from_skid;
    logic             load_skid;

    imm_decode_comb #(
        .XLEN (XLEN)
    ) u_decode (
        .instr   (in_instr),
        .imm     (dec_imm),
        .fmt     (dec_fmt),
        .illegal (dec_illegal)
    );

    assign dec_meta.fmt     = dec_fmt;
    assign dec_meta.illegal = dec_illegal;

    assign accept = in_valid && in_ready_q && !flush;
    assign drain  = out_valid_q && out_ready;

    // Occupancy control: skid drains first, new entries bypass into the output register when it frees.
    always_comb begin
        out_valid_d   = out_valid_q;
        skid_valid_d  = skid_valid_q;
        load_out      = 1'b0;
        out_from_skid = 1'b0;
        load_skid     = 1'b0;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (skid_valid_q) begin
            if (drain) begin
                load_out      = 1'b1;
                out_from_skid = 1'b1;
                skid_valid_d  = 1'b0;
            end
        end else if (accept) begin
            if (!out_valid_q || drain) begin
                load_out    = 1'b1;
                out_valid_d = 1'b1;
            end else begin
                load_skid    = 1'b1;
                skid_valid_d = 1'b1;
            end
        end else if (drain) begin
            out_valid_d = 1'b0;
        end
    end

    // in_ready comes out of reset low and tracks !skid_valid from the first edge on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= !skid_valid_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_imm_q  <= '0;
            out_meta_q <= '0;
            out_tag_q  <= '0;
        end else if (load_out) begin
            out_imm_q  <= out_from_skid ? skid_imm_q  : dec_imm;
            out_meta_q <= out_from_skid ? skid_meta_q : dec_meta;
            out_tag_q  <= out_from_skid ? skid_tag_q  : in_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_imm_q  <= '0;
            skid_meta_q <= '0;
            skid_tag_q  <= '0;
        end else if (load_skid) begin
            skid_imm_q  <= dec_imm;
            skid_meta_q <= dec_meta;
            skid_tag_q  <= in_tag;
        end
    end

    // Saturating illegal counter; survives flush, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (accept && dec_illegal && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_imm     = out_imm_q;
    assign out_fmt     = out_meta_q.fmt;
    assign out_illegal = out_meta_q.illegal;
    assign out_tag     = out_tag_q;
    assign illegal_cnt = cnt_q;

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32: immediate width, legal values 32 or 64.
REQ-002 SHALL have parameter TAG_W, default 32: width of sideband tag (PC) carried with each instruction.
REQ-003 SHALL have port clk  input  1: single clock, all state rising-edge.
REQ-004 SHALL have port rst_n  input  1: asynchronous active-low reset.
REQ-005 SHALL have port flush  input  1: discard all held entries.
REQ-006 SHALL have port in_valid  input  1: upstream instruction valid.
REQ-007 SHALL have port in_ready  output  1: block can accept this cycle.
REQ-008 SHALL have port in_instr  input  32: instruction word.
REQ-009 SHALL have port in_tag  input  TAG_W: sideband tag.
REQ-010 SHALL have port out_valid  output  1: result valid.
REQ-011 SHALL have port out_ready  input  1: downstream accepts.
REQ-012 SHALL have port out_imm  output  XLEN: decoded immediate.
REQ-013 SHALL have port out_fmt  output  3: format code, 0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 7 illegal.
REQ-014 SHALL have port out_illegal  output  1: opcode not recognised.
REQ-015 SHALL have port out_tag  output  TAG_W: tag of the result entry.
REQ-016 SHALL have port illegal_cnt  output  16: saturating count of accepted illegal instructions.

Function
REQ-017 SHALL decode by opcode: 0000011/0010011/1100111 -> I; 0100011 -> S; 1100011 -> B; 0110111/0010111 -> U; 1101111 -> J; 0110011 -> R; any other -> illegal.
REQ-018 SHALL form I = sext(instr[31:20]); S = sext({instr[31:25],instr[11:7]}); B = sext({instr[31],instr[7],instr[30:25],instr[11:8],0}); U = sext({instr[31:12],12'b0}); J = sext({instr[31],instr[19:12],instr[20],instr[30:21],0}); all sign-extended to XLEN.
REQ-019 SHALL, for opcode 0010011 with funct3 001 or 101, output zero-extended shamt: instr[24:20] when XLEN=32, instr[25:20] when XLEN=64.
REQ-020 SHALL output out_imm=0 for R format and for illegal; out_illegal=1 only for illegal.
REQ-021 SHALL register results: an instruction accepted in cycle N appears on outputs in cycle N+1 (latency 1).
REQ-022 SHALL contain one output register plus one skid entry; in_ready SHALL be a registered signal equal to !skid_valid.
REQ-023 SHALL accept when in_valid && in_ready; if output register is empty or being drained (out_ready) the entry goes to the output register, else to the skid entry.
REQ-024 SHALL hold out_imm/out_fmt/out_illegal/out_tag stable while out_valid && !out_ready.
REQ-025 SHALL, on out_ready with skid occupied, move skid into output register next cycle and set in_ready=1 the cycle after the move.
REQ-026 SHALL preserve strict in-order delivery; no entry dropped or duplicated.
REQ-027 SHALL, on flush, clear out_valid and skid_valid next cycle; in_valid in the flush cycle is ignored; in_ready=1 the cycle after flush.
REQ-028 SHALL increment illegal_cnt once per accepted illegal instruction, saturate at 16'hFFFF, and not clear on flush.
REQ-029 SHALL ignore out_ready when out_valid=0.

Reset
REQ-030 SHALL, on rst_n low, asynchronously clear out_valid, skid_valid, out_imm, out_fmt, out_illegal, out_tag, illegal_cnt to 0, and drive in_ready=1 from the first clock after rst_n release.
REQ-031 SHALL discard in-flight entries when reset asserts mid-operation.

Configuration
REQ-032 SHALL honour macro IMM_GEN_ANDI_ZEXT_EN: when defined, opcode 0010011 with funct3 111 (ANDI) yields zero-extended instr[31:20]; when undefined, ANDI is sign-extended like other I-type.

Structure
REQ-033 SHALL take opcode constants and format codes from shared package imm_pkg.
REQ-034 SHALL place combinational decode in sub-module imm_decode_comb (instr, parameter XLEN -> imm, fmt, illegal); imm_gen_pipe holds registers and handshake only.

Verification
REQ-035 SHALL test: lh x1,-4(x2) (0xFFC11083) accepted, out_ready=1 -> next cycle out_imm=0xFFFFFFFC, fmt=1.
REQ-036 SHALL test: beq offset -8 (0xFE000CE3) -> out_imm=0xFFFFFFF8, fmt=3; jal +2048 (0x0010006F) -> 0x00000800, fmt=5.
REQ-037 SHALL test: out_ready=0 for 3 cycles with in_valid=1 -> second instr held in skid, in_ready=0, third not accepted; release -> outputs delivered in order.
REQ-038 SHALL test: opcode 1111111 accepted 65537 times -> illegal_cnt=0xFFFF, out_illegal=1, out_imm=0.
REQ-039 SHALL test: andi x1,x1,0xFFF (0xFFF0F093) -> 0x00000FFF with IMM_GEN_ANDI_ZEXT_EN, 0xFFFFFFFF without.
REQ-040 SHALL test: flush with both entries full -> out_valid=0 next cycle, in_ready=1 the cycle after, illegal_cnt unchanged; XLEN=64 slli shamt 63 -> out_imm=63.
